// File: rtl/ndma_ctrl_if.sv
// ndma_ctrl_if: OBI read and write manager buses of the ndma_ctrl single-channel DMA engine.
// The master modport is the DMA side; the slave modport is the memory/interconnect side.
interface ndma_ctrl_if;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_gnt_i;
    logic        rd_rvalid_i;
    logic [31:0] rd_rdata_i;

    logic        wr_req_o;
    logic        wr_we_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_wdata_o;
    logic [3:0]  wr_be_o;
    logic        wr_gnt_i;
    logic        wr_rvalid_i;

    modport master (
        output rd_req_o, rd_addr_o,
        input  rd_gnt_i, rd_rvalid_i, rd_rdata_i,
        output wr_req_o, wr_we_o, wr_addr_o, wr_wdata_o, wr_be_o,
        input  wr_gnt_i, wr_rvalid_i
    );

    modport slave (
        input  rd_req_o, rd_addr_o,
        output rd_gnt_i, rd_rvalid_i, rd_rdata_i,
        input  wr_req_o, wr_we_o, wr_addr_o, wr_wdata_o, wr_be_o,
        output wr_gnt_i, wr_rvalid_i
    );
endinterface

// File: rtl/ndma_ctrl.sv
// ndma_ctrl: word-by-word memory-to-memory copy engine with one outstanding OBI read or write at a time.
// Define NDMA_IRQ_EN to build the sticky completion interrupt; otherwise irq_o is tied low.
module ndma_ctrl #(
    parameter int unsigned AddrStride = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] rd_addr_i,
    input  logic [31:0] wr_addr_i,
    input  logic [7:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        irq_o,
    ndma_ctrl_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [31:0] Stride = 32'(AddrStride);

    logic [2:0]  state_q, state_d;
    logic [31:0] cur_rd_q, cur_wr_q, buffer_q;
    logic [7:0]  remaining_q;
    logic        start_ok;
    logic        word_done;

    assign start_ok  = (state_q == IDLE) && start_i;
    assign word_done = (state_q == WR_WAIT) && bus.wr_rvalid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (len_i == 8'd0) ? DONE : RD_REQ;
            RD_REQ:  if (bus.rd_gnt_i) state_d = RD_WAIT;
            RD_WAIT: if (bus.rd_rvalid_i) state_d = WR_REQ;
            WR_REQ:  if (bus.wr_gnt_i) state_d = WR_WAIT;
            WR_WAIT: if (bus.wr_rvalid_i) state_d = (remaining_q == 8'd1) ? DONE : RD_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer parameters are only loaded from IDLE, so a start pulse during a transfer cannot disturb them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_rd_q    <= '0;
            cur_wr_q    <= '0;
            remaining_q <= '0;
            buffer_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok && (len_i != 8'd0)) begin
                cur_rd_q    <= rd_addr_i;
                cur_wr_q    <= wr_addr_i;
                remaining_q <= len_i;
            end
            if ((state_q == RD_WAIT) && bus.rd_rvalid_i) begin
                buffer_q <= bus.rd_rdata_i;
            end
            if (word_done && (remaining_q != 8'd1)) begin
                remaining_q <= remaining_q - 8'd1;
                cur_rd_q    <= cur_rd_q + Stride;
                cur_wr_q    <= cur_wr_q + Stride;
            end
        end
    end

    assign bus.rd_req_o   = (state_q == RD_REQ);
    assign bus.rd_addr_o  = bus.rd_req_o ? cur_rd_q : '0;

    assign bus.wr_req_o   = (state_q == WR_REQ);
    assign bus.wr_we_o    = bus.wr_req_o;
    assign bus.wr_be_o    = bus.wr_req_o ? 4'hF : 4'h0;
    assign bus.wr_addr_o  = bus.wr_req_o ? cur_wr_q : '0;
    assign bus.wr_wdata_o = bus.wr_req_o ? buffer_q : '0;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

`ifdef NDMA_IRQ_EN
    logic irq_q;

    // Sticky flag covers the cycles after DONE; the DONE cycle itself is covered combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if (start_ok) begin
            irq_q <= 1'b0;
        end else if (state_q == DONE) begin
            irq_q <= 1'b1;
        end
    end

    assign irq_o = irq_q | done_o;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_ndma_ctrl.sv
// tb_ndma_ctrl: randomized OBI slaves plus an address/data scoreboard derived from the transfer parameters.
// Covers directed corner cases (zero length, grant stall, address wrap, irq, mid-transfer reset) then random transfers.
module tb_ndma_ctrl;
    localparam int Stride = 4;
`ifdef NDMA_IRQ_EN
    localparam bit IrqEn = 1'b1;
`else
    localparam bit IrqEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] rd_addr_i;
    logic [31:0] wr_addr_i;
    logic [7:0]  len_i;
    logic        busy_o;
    logic        done_o;
    logic        irq_o;

    ndma_ctrl_if bus ();

    ndma_ctrl #(.AddrStride(Stride)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .rd_addr_i (rd_addr_i),
        .wr_addr_i (wr_addr_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .irq_o     (irq_o),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    bit          zero_wait;
    bit          noise_en;
    bit          in_reset;
    bit          exp_irq;
    int          rd_gnt_hold;
    bit          rd_out, wr_out, rd_prev_stall, wr_prev_stall;
    int          rd_dly, wr_dly, rd_stall_cnt, wr_stall_cnt;
    logic [31:0] rd_val, rd_prev_addr, wr_prev_addr, wr_prev_data;

    logic [31:0] rd_obs[$];
    logic [31:0] rd_dat[$];
    logic [31:0] wr_obs_a[$];
    logic [31:0] wr_obs_d[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"},   32'(busy_o), 32'd0);
        checkOutput({tag, "_done"},   32'(done_o), 32'd0);
        checkOutput({tag, "_irq"},    32'(irq_o), 32'd0);
        checkOutput({tag, "_rdreq"},  32'(bus.rd_req_o), 32'd0);
        checkOutput({tag, "_rdaddr"}, bus.rd_addr_o, 32'd0);
        checkOutput({tag, "_wrreq"},  32'(bus.wr_req_o), 32'd0);
        checkOutput({tag, "_wrwe"},   32'(bus.wr_we_o), 32'd0);
        checkOutput({tag, "_wrbe"},   32'(bus.wr_be_o), 32'd0);
        checkOutput({tag, "_wraddr"}, bus.wr_addr_o, 32'd0);
        checkOutput({tag, "_wrdata"}, bus.wr_wdata_o, 32'd0);
    endtask

    // OBI slaves: respond to the previous edge's handshake first, then decide this cycle's grant.
    initial begin : obi_slaves
        bus.rd_gnt_i = 1'b0; bus.rd_rvalid_i = 1'b0; bus.rd_rdata_i = '0;
        bus.wr_gnt_i = 1'b0; bus.wr_rvalid_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (in_reset) begin
                rd_out = 0; wr_out = 0; rd_prev_stall = 0; wr_prev_stall = 0;
                bus.rd_gnt_i = 1'b0; bus.rd_rvalid_i = 1'b0;
                bus.wr_gnt_i = 1'b0; bus.wr_rvalid_i = 1'b0;
            end else begin
                checkOutput("bus_exclusive", 32'(bus.rd_req_o & bus.wr_req_o), 32'd0);

                if (rd_out && rd_dly == 0) begin
                    bus.rd_rvalid_i = 1'b1; bus.rd_rdata_i = rd_val; rd_out = 0;
                end else begin
                    if (rd_out) rd_dly--;
                    bus.rd_rvalid_i = !rd_out && noise_en && ($urandom_range(0, 3) == 0);
                    bus.rd_rdata_i  = $urandom;
                end
                if (bus.rd_req_o) begin
                    if (rd_prev_stall) begin
                        checkOutput("rd_addr_stable", bus.rd_addr_o, rd_prev_addr);
                    end else begin
                        rd_stall_cnt = (rd_gnt_hold > 0) ? rd_gnt_hold : (zero_wait ? 0 : int'($urandom_range(0, 3)));
                        rd_gnt_hold  = 0;
                    end
                    bus.rd_gnt_i = (rd_stall_cnt == 0);
                    if (rd_stall_cnt == 0) begin
                        rd_obs.push_back(bus.rd_addr_o);
                        rd_val = $urandom;
                        rd_dat.push_back(rd_val);
                        rd_out = 1; rd_dly = zero_wait ? 0 : int'($urandom_range(0, 2)); rd_prev_stall = 0;
                    end else begin
                        rd_stall_cnt--; rd_prev_stall = 1; rd_prev_addr = bus.rd_addr_o;
                    end
                end else begin
                    checkOutput("rd_req_held", 32'(rd_prev_stall), 32'd0);
                    checkOutput("rd_addr_idle", bus.rd_addr_o, 32'd0);
                    bus.rd_gnt_i  = noise_en && ($urandom_range(0, 1) == 0);
                    rd_prev_stall = 0;
                end

                if (wr_out && wr_dly == 0) begin
                    bus.wr_rvalid_i = 1'b1; wr_out = 0;
                end else begin
                    if (wr_out) wr_dly--;
                    bus.wr_rvalid_i = !wr_out && noise_en && ($urandom_range(0, 3) == 0);
                end
                if (bus.wr_req_o) begin
                    if (wr_prev_stall) begin
                        checkOutput("wr_addr_stable", bus.wr_addr_o, wr_prev_addr);
                        checkOutput("wr_data_stable", bus.wr_wdata_o, wr_prev_data);
                    end else begin
                        wr_stall_cnt = zero_wait ? 0 : int'($urandom_range(0, 3));
                    end
                    bus.wr_gnt_i = (wr_stall_cnt == 0);
                    if (wr_stall_cnt == 0) begin
                        checkOutput("wr_we", 32'(bus.wr_we_o), 32'd1);
                        checkOutput("wr_be", 32'(bus.wr_be_o), 32'hF);
                        wr_obs_a.push_back(bus.wr_addr_o);
                        wr_obs_d.push_back(bus.wr_wdata_o);
                        wr_out = 1; wr_dly = zero_wait ? 0 : int'($urandom_range(0, 2)); wr_prev_stall = 0;
                    end else begin
                        wr_stall_cnt--; wr_prev_stall = 1;
                        wr_prev_addr = bus.wr_addr_o; wr_prev_data = bus.wr_wdata_o;
                    end
                end else begin
                    checkOutput("wr_req_held", 32'(wr_prev_stall), 32'd0);
                    checkOutput("wr_addr_idle", bus.wr_addr_o, 32'd0);
                    checkOutput("wr_data_idle", bus.wr_wdata_o, 32'd0);
                    bus.wr_gnt_i  = noise_en && ($urandom_range(0, 1) == 0);
                    wr_prev_stall = 0;
                end
            end
        end
    end

    // One transfer from a negedge: expected traffic is base + i*Stride with write data equal to the i-th read data.
    task automatic applyStimulus(input logic [31:0] rd, input logic [31:0] wr, input logic [7:0] len,
                                 input bit restart, input int extra);
        int cycle;
        int bound;
        int n;
        bit seen_done;
        rd_obs.delete(); rd_dat.delete(); wr_obs_a.delete(); wr_obs_d.delete();
        checkOutput("busy_idle", 32'(busy_o), 32'd0);
        checkOutput("irq_idle", 32'(irq_o), 32'(exp_irq));
        start_i = 1'b1; rd_addr_i = rd; wr_addr_i = wr; len_i = len;
        cycle = 0; seen_done = 0; bound = 16 * int'(len) + 8 + extra;
        while (!seen_done && cycle < bound) begin
            @(negedge clk_i);
            cycle++;
            start_i   = restart && (cycle == 2);
            rd_addr_i = $urandom; wr_addr_i = $urandom; len_i = 8'($urandom);
            checkOutput("busy_run", 32'(busy_o), 32'd1);
            if (done_o) begin
                seen_done = 1;
                checkOutput("irq_done", 32'(irq_o), 32'(IrqEn));
            end else begin
                checkOutput("irq_run", 32'(irq_o), 32'd0);
            end
        end
        start_i = 1'b0;
        checkOutput("done_seen", 32'(seen_done), 32'd1);
        if (zero_wait) checkOutput("done_cycle", 32'(cycle), 32'(4 * int'(len) + 1 + extra));
        @(negedge clk_i);
        exp_irq = IrqEn;
        checkOutput("done_pulse", 32'(done_o), 32'd0);
        checkOutput("busy_after", 32'(busy_o), 32'd0);
        checkOutput("irq_hold", 32'(irq_o), 32'(exp_irq));
        checkOutput("rd_count", 32'(rd_obs.size()), 32'(len));
        checkOutput("wr_count", 32'(wr_obs_a.size()), 32'(len));
        n = (rd_obs.size() < int'(len)) ? rd_obs.size() : int'(len);
        for (int i = 0; i < n; i++) begin
            checkOutput("rd_addr", rd_obs[i], rd + 32'(i * Stride));
        end
        n = (wr_obs_a.size() < int'(len)) ? wr_obs_a.size() : int'(len);
        for (int i = 0; i < n; i++) begin
            checkOutput("wr_addr", wr_obs_a[i], wr + 32'(i * Stride));
            if (i < rd_dat.size()) checkOutput("wr_data", wr_obs_d[i], rd_dat[i]);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            checkOutput("idle_busy", 32'(busy_o), 32'd0);
            checkOutput("idle_irq", 32'(irq_o), 32'(exp_irq));
        end
    endtask

    // Second start during the transfer must be ignored; reset while in WR_REQ must silence everything.
    task automatic resetMidTransfer();
        int cycle;
        bit reached;
        zero_wait = 1; noise_en = 0;
        rd_obs.delete(); rd_dat.delete(); wr_obs_a.delete(); wr_obs_d.delete();
        start_i = 1'b1; rd_addr_i = 32'h0000_3000; wr_addr_i = 32'h0000_4000; len_i = 8'd4;
        cycle = 0; reached = 0;
        while (!reached && cycle < 20) begin
            @(negedge clk_i);
            cycle++;
            start_i   = (cycle == 2);
            rd_addr_i = 32'h0000_5000; wr_addr_i = 32'h0000_6000; len_i = 8'd9;
            reached   = bus.wr_req_o;
        end
        start_i = 1'b0;
        checkOutput("reach_wr_req", 32'(reached), 32'd1);
        checkOutput("mid_rd_seen", 32'(rd_obs.size()), 32'd1);
        if (rd_obs.size() > 0) checkOutput("mid_rd_addr", rd_obs[0], 32'h0000_3000);
        checkOutput("mid_wr_addr", bus.wr_addr_o, 32'h0000_4000);
        if (rd_dat.size() > 0) checkOutput("mid_wr_data", bus.wr_wdata_o, rd_dat[0]);
        rst_i = 1'b1; in_reset = 1;
        @(negedge clk_i);
        checkIdleOutputs("mid_reset");
        rst_i = 1'b0;
        exp_irq = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (i == 1) in_reset = 0;
            checkOutput("post_rst_done", 32'(done_o), 32'd0);
            checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
            checkOutput("post_rst_irq", 32'(irq_o), 32'd0);
            checkOutput("post_rst_req", 32'(bus.rd_req_o | bus.wr_req_o), 32'd0);
        end
    endtask

    initial begin : main
        logic [7:0] len;
        rst_i = 1'b1; start_i = 1'b0; rd_addr_i = '0; wr_addr_i = '0; len_i = '0;
        in_reset = 1; zero_wait = 1; noise_en = 0; rd_gnt_hold = 0; exp_irq = 0;
        repeat (3) @(negedge clk_i);
        checkIdleOutputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        in_reset = 0;

        $display("[TB] directed: zero-wait copy of 3 words");
        applyStimulus(32'h0000_1000, 32'h0000_2000, 8'd3, 1'b0, 0);
        idleCycles(2);

        $display("[TB] directed: zero length");
        applyStimulus(32'h0000_1000, 32'h0000_2000, 8'd0, 1'b0, 0);
        idleCycles(1);

        $display("[TB] directed: read grant held low 5 cycles");
        rd_gnt_hold = 5;
        applyStimulus(32'h0000_0100, 32'h0000_0200, 8'd2, 1'b0, 5);

        $display("[TB] directed: address wrap");
        applyStimulus(32'hFFFF_FFFC, 32'hFFFF_FFF8, 8'd2, 1'b0, 0);
        checkOutput("wrap_rd1", (rd_obs.size() > 1) ? rd_obs[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        $display("[TB] directed: single word with completion interrupt");
        applyStimulus(32'h0000_8000, 32'h0000_9000, 8'd1, 1'b0, 0);
        idleCycles(3);
        applyStimulus(32'h0000_8100, 32'h0000_9100, 8'd1, 1'b1, 0);

        $display("[TB] directed: restart pulse then reset in WR_REQ");
        resetMidTransfer();

        $display("[TB] random transfers");
        for (int t = 0; t < 25; t++) begin
            zero_wait = ($urandom_range(0, 3) == 0);
            noise_en  = 1;
            len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            applyStimulus($urandom, $urandom, len, (len != 8'd0) && ($urandom_range(0, 1) == 1), 0);
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
